// File: rtl/traffic_alu_pkg.sv
// Shared constants for the traffic-controller serial ALU: b-operand control
// encodings, FSM state encodings and the bit-counter width helper.
package traffic_alu_pkg;

    // b-operand control for the adder slice
    localparam logic [1:0] OP_ZERO = 2'b00;
    localparam logic [1:0] OP_B    = 2'b01;
    localparam logic [1:0] OP_NB   = 2'b10;
    localparam logic [1:0] OP_ONES = 2'b11;

    // Sequencer states (fixed legacy encoding)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit-counter width: max(1, clog2(w))
    function automatic int unsigned cnt_width(input int unsigned w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ctrl_fa_slice.sv
// Controlled full-adder slice: selects the effective b bit from op, then
// adds it to a and the incoming carry. Purely combinational.
module ctrl_fa_slice
    import traffic_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       sum,
    output logic       cout
);

    logic b1;

    // Effective b operand: zero, b, ~b or one
    always_comb begin
        b1 = 1'b0;
        case (op)
            OP_ZERO: b1 = 1'b0;
            OP_B:    b1 = b;
            OP_NB:   b1 = ~b;
            OP_ONES: b1 = 1'b1;
            default: b1 = 1'b0;
        endcase
    end

    assign sum  = a ^ b1 ^ cin;
    assign cout = (a & b1) | (cin & (a ^ b1));

endmodule

// File: rtl/serial_ctrl_alu.sv
// Bit-serial controlled adder: one ctrl_fa_slice is reused over WIDTH cycles
// to compute y = a + B' + cin, with B' chosen by op.
// Optional feature macro: SERIAL_ALU_FLAGS_EN enables the zero/ovf flags;
// without it both flags are tied low and their logic is absent.
module serial_ctrl_alu
    import traffic_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [1:0]       op_q;
    logic             carry;
    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
    logic             accept;

    ctrl_fa_slice u_slice (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .op   (op_q),
        .sum  (s_bit),
        .cout (c_bit)
    );

    // Accumulator after shifting the current sum bit into the MSB
    always_comb begin
        acc_nxt            = acc >> 1;
        acc_nxt[WIDTH-1]   = s_bit;
    end

    assign last_bit = (state == ST_SHIFT) && (cnt == LAST);
    // DONE also samples start so back-to-back operations run every WIDTH+1 cycles
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy     = (state != ST_IDLE);

    // Sequencer, operand shift registers, carry flop and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            op_q  <= '0;
            carry <= 1'b0;
            y     <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        op_q  <= op;
                        carry <= cin;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= c_bit;
                    acc   <= acc_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        y     <= acc_nxt;
                        cout  <= c_bit;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    // Flags captured on the final-bit edge; carry still holds c[WIDTH-1] there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_bit) begin
            zero <= (acc_nxt == '0);
            ovf  <= c_bit ^ carry;
        end
    end
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_ctrl_alu.sv
// Self-checking bench for serial_ctrl_alu (WIDTH=8): directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_serial_ctrl_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = '0;
    logic       cin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, cout, zero, ovf;
    logic [7:0] y;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] y_prev = '0;

`ifdef SERIAL_ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    serial_ctrl_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .cout  (cout),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {zero, ovf, cout, y}
    function automatic logic [10:0] model(input int unsigned ta, input int unsigned tb,
                                          input int unsigned top, input int unsigned tc);
        int unsigned bv, sum;
        int sa, sb, ss;
        logic [7:0] ry;
        logic rc, ro, rz;
        case (top)
            0: bv = 0;
            1: bv = tb;
            2: bv = 255 - tb;
            default: bv = 255;
        endcase
        sum = ta + bv + tc;
        ry  = 8'(sum % 256);
        rc  = (sum >= 256);
        sa  = (ta >= 128) ? int'(ta) - 256 : int'(ta);
        sb  = (bv >= 128) ? int'(bv) - 256 : int'(bv);
        ss  = sa + sb + int'(tc);
        ro  = FLAGS && ((ss > 127) || (ss < -128));
        rz  = FLAGS && (sum % 256 == 0);
        return {rz, ro, rc, ry};
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                          input logic tcin, input bit abuse);
        logic [10:0] e;
        int dones;
        e = model(ta, tb, top, tcin);
        dones = 0;
        a = ta; b = tb; op = top; cin = tcin; start = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy", busy, 1);
        chk("accept_done_low", done, 0);
        start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (abuse && cyc == 3) start = 1'b1;
            if (abuse && cyc == 4) begin
                start = 1'b0; a = ~ta; b = 8'($urandom); op = ~top; cin = ~tcin;
            end
            if (abuse && cyc == 8) start = 1'b1;
            @(posedge clk); #1;
            if (cyc < 8) begin
                chk("busy_mid", busy, 1);
                if (done) dones++;
            end
            if (cyc == 4) chk("y_held", y, y_prev);
        end
        start = 1'b0;
        chk("early_done", dones, 0);
        chk("done_at_w", done, 1);
        chk("busy_in_done", busy, 1);
        chk("y", y, e[7:0]);
        chk("cout", cout, e[8]);
        chk("ovf", ovf, e[9]);
        chk("zero", zero, e[10]);
        y_prev = e[7:0];
        if (abuse) begin
            dones = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (done) dones++;
            end
            chk("extra_done", dones, 0);
            chk("idle_after_abuse", busy, 0);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_y", y, 0);
        chk("rst_cout", cout, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk) rst_n = 1'b1;
        idle_cycle();

        // Directed arithmetic cases
        run_op(8'h3C, 8'h15, 2'b01, 1'b0, 0); idle_cycle();
        run_op(8'h15, 8'h3C, 2'b10, 1'b1, 0); idle_cycle();
        run_op(8'h80, 8'h01, 2'b10, 1'b1, 0); idle_cycle();
        run_op(8'hFF, 8'h5A, 2'b00, 1'b1, 0); idle_cycle();
        run_op(8'h00, 8'hA5, 2'b11, 1'b0, 0); idle_cycle();
        run_op(8'h7F, 8'h01, 2'b01, 1'b0, 0); idle_cycle();

        // Start pulses while busy and operand changes mid-flight
        run_op(8'h9C, 8'h27, 2'b01, 1'b1, 1);

        // Back-to-back: second start sampled on the edge leaving the done cycle
        run_op(8'h12, 8'h34, 2'b01, 1'b0, 0);
        run_op(8'hC8, 8'h64, 2'b10, 1'b1, 0);
        run_op(8'h01, 8'h00, 2'b11, 1'b0, 0);
        idle_cycle();

        // Reset in the middle of an operation
        a = 8'h55; b = 8'h66; op = 2'b01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_y", y, 0);
        chk("abort_cout", cout, 0);
        y_prev = '0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) @(negedge clk) rst_n = 1'b1;
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_y_after", y, 0);
        run_op(8'hA0, 8'h0F, 2'b01, 1'b1, 0); idle_cycle();

        // Randomized operations, some back-to-back
        for (int n = 0; n < 40; n++) begin
            run_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
        chk("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
